// File: rtl/psram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-transaction HyperRAM controller.
// Define PSRAM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority over B.
module psram_arbiter #(
  parameter int          START_WAIT     = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] ABORT_DATA     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_write,
  input  logic [21:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_write,
  input  logic [21:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic        mem_cmd_en,
  output logic        mem_cmd_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_wr_data,
  input  logic [15:0] mem_rd_data,
  input  logic        mem_data_valid,
  input  logic        mem_busy,
  output logic        owner,
  output logic        timeout_err
);

  localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] START_LAST = WD_W'(START_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Port 0 is A, port 1 is B throughout.
  logic [1:0]  req;
  logic [1:0]  write_sel;
  logic [21:0] addr_in  [2];
  logic [15:0] wdata_in [2];

  assign req         = {b_req, a_req};
  assign write_sel   = {b_write, a_write};
  assign addr_in[0]  = a_addr;
  assign addr_in[1]  = b_addr;
  assign wdata_in[0] = a_wdata;
  assign wdata_in[1] = b_wdata;

  logic [1:0]      ack_reg, ack_next;
  logic [1:0]      rvalid_reg, rvalid_next;
  logic [15:0]     rdata_reg [2];
  logic [15:0]     rdata_next [2];
  logic            cmd_en_reg, cmd_en_next;
  logic            cmd_write_reg, cmd_write_next;
  logic [21:0]     addr_reg, addr_next;
  logic [15:0]     wr_data_reg, wr_data_next;
  logic            owner_reg, owner_next;
  logic            timeout_err_reg, timeout_err_next;
  logic            rd_done_reg, rd_done_next;
  logic [WD_W-1:0] watchdog_reg, watchdog_next;

  logic grant;
  logic win;
  logic wd_hit;
  logic start_hit;
  logic abort;
  logic capture;
  logic abort_rvalid;

  always_comb begin
`ifdef PSRAM_ARB_RR_EN
    // On a tie the port that did not win last time goes first.
    win = req[1] && (!req[0] || !owner_reg);
`else
    win = !req[0];
`endif
  end

  assign grant     = (state_reg == IDLE) && !mem_busy && (|req);
  assign wd_hit    = (watchdog_reg == WD_LAST);
  assign start_hit = (watchdog_reg == START_LAST);

  always_comb begin
    abort = 1'b0;
    case (state_reg)
      WAIT_START: abort = (start_hit && !mem_busy) || wd_hit;
      WAIT_DONE:  abort = mem_busy && wd_hit;
      default:    abort = 1'b0;
    endcase
  end

  assign capture      = (state_reg == WAIT_DONE) && mem_data_valid
                        && !cmd_write_reg && !rd_done_reg;
  // A read that already got real data this cycle does not also get ABORT_DATA.
  assign abort_rvalid = abort && !cmd_write_reg && !rd_done_reg && !capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = WAIT_START;
      end
      WAIT_START: begin
        if (abort)         state_next = IDLE;
        else if (mem_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!mem_busy || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_next         = '0;
    rvalid_next      = '0;
    rdata_next       = rdata_reg;
    cmd_en_next      = 1'b0;
    cmd_write_next   = cmd_write_reg;
    addr_next        = addr_reg;
    wr_data_next     = wr_data_reg;
    owner_next       = owner_reg;
    timeout_err_next = timeout_err_reg;
    rd_done_next     = rd_done_reg;
    watchdog_next    = watchdog_reg;

    case (state_reg)
      IDLE: begin
        if (grant) begin
          cmd_en_next    = 1'b1;
          cmd_write_next = write_sel[win];
          addr_next      = addr_in[win];
          wr_data_next   = wdata_in[win];
          owner_next     = win;
          ack_next[win]  = 1'b1;
          rd_done_next   = 1'b0;
        end
      end
      ISSUE: begin
        watchdog_next = '0;
      end
      WAIT_START, WAIT_DONE: begin
        watchdog_next = watchdog_reg + 1'b1;
      end
      default: ;
    endcase

    if (capture) begin
      rdata_next[owner_reg]  = mem_rd_data;
      rvalid_next[owner_reg] = 1'b1;
      rd_done_next           = 1'b1;
    end

    if (abort) begin
      timeout_err_next = 1'b1;
      if (abort_rvalid) begin
        rdata_next[owner_reg]  = ABORT_DATA;
        rvalid_next[owner_reg] = 1'b1;
        rd_done_next           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg         <= '0;
      rvalid_reg      <= '0;
      rdata_reg[0]    <= '0;
      rdata_reg[1]    <= '0;
      cmd_en_reg      <= 1'b0;
      cmd_write_reg   <= 1'b0;
      addr_reg        <= '0;
      wr_data_reg     <= '0;
      owner_reg       <= 1'b1;
      timeout_err_reg <= 1'b0;
      rd_done_reg     <= 1'b0;
      watchdog_reg    <= '0;
    end else begin
      ack_reg         <= ack_next;
      rvalid_reg      <= rvalid_next;
      rdata_reg[0]    <= rdata_next[0];
      rdata_reg[1]    <= rdata_next[1];
      cmd_en_reg      <= cmd_en_next;
      cmd_write_reg   <= cmd_write_next;
      addr_reg        <= addr_next;
      wr_data_reg     <= wr_data_next;
      owner_reg       <= owner_next;
      timeout_err_reg <= timeout_err_next;
      rd_done_reg     <= rd_done_next;
      watchdog_reg    <= watchdog_next;
    end
  end

  assign a_ack         = ack_reg[0];
  assign b_ack         = ack_reg[1];
  assign a_rvalid      = rvalid_reg[0];
  assign b_rvalid      = rvalid_reg[1];
  assign a_rdata       = rdata_reg[0];
  assign b_rdata       = rdata_reg[1];
  assign mem_cmd_en    = cmd_en_reg;
  assign mem_cmd_write = cmd_write_reg;
  assign mem_addr      = addr_reg;
  assign mem_wr_data   = wr_data_reg;
  assign owner         = owner_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter with a small behavioural HyperRAM controller model.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_write, a_ack, a_rvalid;
  logic [21:0] a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        b_req, b_write, b_ack, b_rvalid;
  logic [21:0] b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic        mem_cmd_en, mem_cmd_write, mem_data_valid, mem_busy;
  logic [21:0] mem_addr;
  logic [15:0] mem_wr_data, mem_rd_data;
  logic        owner, timeout_err;

  always #5 clk = ~clk;

  psram_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_write(mem_cmd_write), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_data_valid(mem_data_valid), .mem_busy(mem_busy),
    .owner(owner), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [21:0] addr;
    logic [15:0] wd;
  } grant_t;

  grant_t      exp_grant [$];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: busy for model_busy_len cycles after a strobe, read data near the end.
  int          model_busy_len = 9;
  bit          model_silent   = 1'b0;
  bit          model_double   = 1'b0;
  logic [15:0] model_rdata    = 16'h0;
  logic [15:0] model_rdata2   = 16'h0;
  int          busy_cnt       = 0;
  logic        cur_write      = 1'b0;

  always @(posedge clk) begin
    mem_data_valid <= 1'b0;
    if (reset) begin
      mem_busy    <= 1'b0;
      mem_rd_data <= 16'h0;
      busy_cnt    <= 0;
    end else if (mem_cmd_en && !model_silent) begin
      mem_busy  <= 1'b1;
      busy_cnt  <= model_busy_len;
      cur_write <= mem_cmd_write;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (!cur_write && model_double && busy_cnt == 3) begin
        mem_data_valid <= 1'b1;
        mem_rd_data    <= model_rdata;
      end
      if (!cur_write && busy_cnt == 2) begin
        mem_data_valid <= 1'b1;
        mem_rd_data    <= model_double ? model_rdata2 : model_rdata;
      end
      if (busy_cnt == 1) mem_busy <= 1'b0;
    end
  end

  // Monitor: every strobe/ack and every rvalid must match the head of its queue.
  always @(negedge clk) begin
    grant_t g;
    if (mem_cmd_en || a_ack || b_ack) begin
      if (exp_grant.size() == 0) begin
        chk("grant_unexpected", 64'({mem_cmd_en, a_ack, b_ack}), 64'(0));
      end else begin
        g = exp_grant.pop_front();
        chk("cmd_en", 64'(mem_cmd_en), 64'(1));
        chk("ack_port", 64'({a_ack, b_ack}), g.port ? 64'(2'b01) : 64'(2'b10));
        chk("owner", 64'(owner), 64'(g.port));
        chk("cmd_write", 64'(mem_cmd_write), 64'(g.wr));
        chk("mem_addr", 64'(mem_addr), 64'(g.addr));
        chk("mem_wr_data", 64'(mem_wr_data), 64'(g.wd));
        $display("grant port=%0d wr=%0d addr=%06h wd=%04h", g.port, g.wr, mem_addr, mem_wr_data);
      end
    end
    if (a_rvalid) begin
      if (exp_a.size() == 0) chk("a_rvalid_unexpected", 64'(a_rdata), 64'h1_0000);
      else chk("a_rdata", 64'(a_rdata), 64'(exp_a.pop_front()));
      $display("a_rvalid rdata=%04h", a_rdata);
    end
    if (b_rvalid) begin
      if (exp_b.size() == 0) chk("b_rvalid_unexpected", 64'(b_rdata), 64'h1_0000);
      else chk("b_rdata", 64'(b_rdata), 64'(exp_b.pop_front()));
      $display("b_rvalid rdata=%04h", b_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input bit port, input bit wr, input logic [21:0] addr,
                         input logic [15:0] wd);
    bit got = 1'b0;
    exp_grant.push_back('{port: port, wr: wr, addr: addr, wd: wd});
    if (!port) begin
      a_req = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (port ? b_ack : a_ack) begin
        got = 1'b1;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    if (!got) chk("ack_timeout", 64'(0), 64'(1));
  endtask

  // Cycles from the ack to the owner's rvalid.
  task automatic wait_rvalid(input bit port, input int exp_lat, input string name);
    int n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (port ? b_rvalid : a_rvalid) begin
        n = i;
        break;
      end
    end
    chk(name, 64'(n), 64'(exp_lat));
  endtask

  task automatic check_reset_state(input string name);
    chk(name, 64'(|{a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata, mem_cmd_en,
                    mem_cmd_write, mem_addr, mem_wr_data, timeout_err}), 64'(0));
    chk("reset_owner", 64'(owner), 64'(1));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    a_req = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    tick(3);
    check_reset_state("reset_outputs");
    reset = 1'b0;
    tick(2);

    // A read; second data_valid pulse must be ignored.
    model_busy_len = 9; model_double = 1'b1;
    model_rdata = 16'h1234; model_rdata2 = 16'h9999;
    exp_a.push_back(16'h1234);
    request(1'b0, 1'b0, 22'h12345, 16'h0000);
    wait_rvalid(1'b0, 9, "a_read_latency");
    model_double = 1'b0;
    tick(4);

    // B write: ack only, no rvalid.
    request(1'b1, 1'b1, 22'h00ABC, 16'h55AA);
    tick(14);

    // Both ports request together and hold.
    model_busy_len = 3;
    exp_grant.push_back('{port: 1'b0, wr: 1'b1, addr: 22'h100, wd: 16'hA001});
`ifdef PSRAM_ARB_RR_EN
    exp_grant.push_back('{port: 1'b1, wr: 1'b1, addr: 22'h200, wd: 16'hB002});
`else
    exp_grant.push_back('{port: 1'b0, wr: 1'b1, addr: 22'h100, wd: 16'hA001});
`endif
    exp_grant.push_back('{port: 1'b0, wr: 1'b1, addr: 22'h100, wd: 16'hA001});
    a_req = 1'b1; a_write = 1'b1; a_addr = 22'h100; a_wdata = 16'hA001;
    b_req = 1'b1; b_write = 1'b1; b_addr = 22'h200; b_wdata = 16'hB002;
    n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) n++;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("tie_grant_count", 64'(n), 64'(3));
    tick(10);

    // Controller never goes busy: start-wait abort.
    model_silent = 1'b1;
    exp_a.push_back(16'hFFFF);
    request(1'b0, 1'b0, 22'h3FFFFF, 16'h0000);
    wait_rvalid(1'b0, 5, "start_abort_latency");
    chk("timeout_err_start", 64'(timeout_err), 64'(1));
    model_silent = 1'b0;
    tick(3);

    // Next B read after the abort is served normally.
    model_busy_len = 5; model_rdata = 16'hBEEF;
    exp_b.push_back(16'hBEEF);
    request(1'b1, 1'b0, 22'h000001, 16'h0000);
    wait_rvalid(1'b1, 6, "b_read_latency");
    tick(4);

    // Controller stuck busy: watchdog abort on B read.
    model_busy_len = 100; model_rdata = 16'h7777;
    exp_b.push_back(16'hFFFF);
    request(1'b1, 1'b0, 22'h2AAAAA, 16'h0000);
    wait_rvalid(1'b1, 65, "watchdog_latency");
    tick(50);
    chk("timeout_err_sticky", 64'(timeout_err), 64'(1));

    // Reset in WAIT_DONE of an A read: abandoned silently.
    model_busy_len = 20; model_rdata = 16'h5A5A;
    request(1'b0, 1'b0, 22'h00F0F0, 16'h0000);
    tick(6);
    reset = 1'b1;
    tick(1);
    check_reset_state("reset_mid_txn");
    reset = 1'b0;
    tick(3);

    model_busy_len = 5; model_rdata = 16'h4321;
    exp_a.push_back(16'h4321);
    request(1'b0, 1'b0, 22'h000123, 16'h0000);
    wait_rvalid(1'b0, 6, "post_reset_read");
    tick(10);

    chk("grant_queue_empty", 64'(exp_grant.size()), 64'(0));
    chk("a_queue_empty", 64'(exp_a.size()), 64'(0));
    chk("b_queue_empty", 64'(exp_b.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
